// File: rtl/pitch_tracker_if.sv
// Sample stream into a pitch tracker and the phase-increment result coming back out.
interface pitch_tracker_if #(
    parameter int unsigned SAMPLE_WIDTH = 11,
    parameter int unsigned PERIOD_WIDTH = 16
);
    logic [SAMPLE_WIDTH-1:0] audio_in;
    logic                    audio_valid_in;
    logic [31:0]             phase_incr_out;
    logic [PERIOD_WIDTH-1:0] period_out;
    logic                    phase_incr_valid_out;
    logic                    busy_out;

    modport master (
        output audio_in,
        output audio_valid_in,
        input  phase_incr_out,
        input  period_out,
        input  phase_incr_valid_out,
        input  busy_out
    );

    modport slave (
        input  audio_in,
        input  audio_valid_in,
        output phase_incr_out,
        output period_out,
        output phase_incr_valid_out,
        output busy_out
    );
endinterface

// File: rtl/pitch_tracker.sv
// Rising zero-crossing period tracker with hysteresis; converts the period into a
// synthesizer phase increment floor(2^32/period) using a 33-step restoring divider.
module pitch_tracker #(
    parameter int unsigned SAMPLE_WIDTH = 11,
    parameter int unsigned HYST         = 16,
    parameter int unsigned MIN_PERIOD   = 8,
    parameter int unsigned PERIOD_WIDTH = 16
) (
    input  logic           clk_in,
    input  logic           rst_in,
    pitch_tracker_if.slave bus
);
    localparam int unsigned SW1 = SAMPLE_WIDTH + 1;
    localparam int unsigned PW  = PERIOD_WIDTH;
    localparam int unsigned PW1 = PERIOD_WIDTH + 1;
    localparam int unsigned QW  = 33;
    localparam int unsigned IW  = 6;

    localparam logic [IW-1:0]         LAST_ITER = IW'(QW - 1);
    localparam logic signed [SW1-1:0] HYST_POS  = SW1'(HYST);
    localparam logic signed [SW1-1:0] HYST_NEG  = -HYST_POS;
    localparam logic [PW1-1:0]        MIN_P     = PW1'(MIN_PERIOD);
    localparam logic [QW-1:0]         DIVIDEND  = {1'b1, 32'd0};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic          armed, armed_nxt;
    logic          have_ref, have_ref_nxt;
    logic [PW-1:0] cnt, cnt_nxt;

    logic [QW-1:0] quo, quo_nxt;
    logic [PW-1:0] rem, rem_nxt;
    logic [PW-1:0] divisor, divisor_nxt;
    logic [IW-1:0] iter, iter_nxt;

    logic [31:0]   phase_q, phase_nxt;
    logic [PW-1:0] period_q, period_nxt;
    logic          valid_q, valid_nxt;
    logic          busy_q, busy_nxt;

    logic signed [SW1-1:0] audio_s;
    logic                  crossing;
    logic                  cnt_sat;
    logic [PW1-1:0]        period_ext;
    logic                  start;
    logic [PW1-1:0]        rem_sh;
    logic [PW-1:0]         rem_sub;

    assign audio_s    = $signed({bus.audio_in[SAMPLE_WIDTH-1], bus.audio_in});
    assign crossing   = bus.audio_valid_in && armed && (audio_s >= HYST_POS);
    assign cnt_sat    = &cnt;
    assign period_ext = PW1'(cnt) + PW1'(1);
    // A DONE cycle is already free: the next division may load on the same edge.
    assign start      = crossing && have_ref && !cnt_sat && (period_ext >= MIN_P)
                        && (state != S_DIV);

    assign rem_sh  = {rem, quo[QW-1]};
    assign rem_sub = PW'(rem_sh - {1'b0, divisor});

    // Hysteresis arming and the saturating sample counter
    always_comb begin
        armed_nxt    = armed;
        have_ref_nxt = have_ref;
        cnt_nxt      = cnt;
        if (bus.audio_valid_in) begin
            if (crossing) begin
                armed_nxt    = 1'b0;
                have_ref_nxt = 1'b1;
                cnt_nxt      = '0;
            end else begin
                if (audio_s < HYST_NEG) armed_nxt = 1'b1;
                if (!cnt_sat) cnt_nxt = cnt + PW'(1);
            end
        end
    end

    // Divider FSM next-state and datapath
    always_comb begin
        state_nxt   = state;
        quo_nxt     = quo;
        rem_nxt     = rem;
        divisor_nxt = divisor;
        iter_nxt    = iter;
        phase_nxt   = phase_q;
        period_nxt  = period_q;
        valid_nxt   = 1'b0;
        busy_nxt    = (state == S_DIV);

        case (state)
            S_IDLE: ;
            S_DIV: begin
                if (rem_sh >= {1'b0, divisor}) begin
                    rem_nxt = rem_sub;
                    quo_nxt = {quo[QW-2:0], 1'b1};
                end else begin
                    rem_nxt = rem_sh[PW-1:0];
                    quo_nxt = {quo[QW-2:0], 1'b0};
                end
                iter_nxt = iter + IW'(1);
                if (iter == LAST_ITER) state_nxt = S_DONE;
            end
            S_DONE: begin
                phase_nxt  = quo[31:0];
                period_nxt = divisor;
                valid_nxt  = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (start) begin
            state_nxt   = S_DIV;
            quo_nxt     = DIVIDEND;
            rem_nxt     = '0;
            divisor_nxt = period_ext[PW-1:0];
            iter_nxt    = '0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= S_IDLE;
            armed    <= 1'b0;
            have_ref <= 1'b0;
            cnt      <= '0;
            quo      <= '0;
            rem      <= '0;
            divisor  <= '0;
            iter     <= '0;
            phase_q  <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            armed    <= armed_nxt;
            have_ref <= have_ref_nxt;
            cnt      <= cnt_nxt;
            quo      <= quo_nxt;
            rem      <= rem_nxt;
            divisor  <= divisor_nxt;
            iter     <= iter_nxt;
            phase_q  <= phase_nxt;
            period_q <= period_nxt;
            valid_q  <= valid_nxt;
            busy_q   <= busy_nxt;
        end
    end

    assign bus.phase_incr_out       = phase_q;
    assign bus.period_out           = period_q;
    assign bus.phase_incr_valid_out = valid_q;
    assign bus.busy_out             = busy_q;
endmodule

// File: doc/pitch_tracker.md
# pitch_tracker

Analysis-side counterpart to the sine synthesizer. It consumes signed audio samples, detects rising zero crossings with hysteresis, and measures the period in samples between consecutive crossings. It converts that period into the synthesizer's 32-bit phase increment, `floor(2^32 / period)`, using an iterative divider. The result can drive a synthesizer's `phase_incr_in` directly to resynthesize the tracked pitch.

## Interface

Parameters:
- `SAMPLE_WIDTH`, 11: signed audio sample width.
- `HYST`, 16: hysteresis threshold in LSBs, range 0..1023.
- `MIN_PERIOD`, 8: shortest accepted period in samples. Must be ≥ 2.
- `PERIOD_WIDTH`, 16: period counter width. The counter saturates at `2^PERIOD_WIDTH-1`.

Ports:
- `clk_in`, input, 1: system clock.
- `rst_in`, input, 1: reset, asynchronous and active-high.
- `audio_in`, input, `SAMPLE_WIDTH`: signed audio sample.
- `audio_valid_in`, input, 1: sample strobe; `audio_in` is consumed on each cycle it is high.
- `phase_incr_out`, output, 32: latest phase increment, `floor(2^32/period)`.
- `period_out`, output, `PERIOD_WIDTH`: period that produced `phase_incr_out`.
- `phase_incr_valid_out`, output, 1: one-cycle pulse when both outputs update.
- `busy_out`, output, 1: divider running.

## Operation

- All sample-side logic advances only on edges where `audio_valid_in` is high. Comparisons are signed.
- Hysteresis:
  - `armed` is set when `audio_in < -HYST`.
  - A rising crossing occurs on a sample with `armed=1` and `audio_in >= HYST`. The crossing clears `armed`.
  - A single sample cannot both arm and trigger.
- Period counter `cnt`:
  - `cnt` is cleared to 0 on a crossing sample.
  - On every other valid sample it increments, saturating at all-ones.
  - At a crossing, `period = cnt+1`, computed at `PERIOD_WIDTH+1` bits. Example: crossings at sample indices 0 and 10 give period 10.
- Crossing classification, using `have_ref` (cleared by reset):
  - `have_ref=0`: the crossing only sets `have_ref=1`; no output.
  - `cnt` saturated: timeout. No output; `have_ref` stays 1 and the counter restarts from this crossing.
  - `period < MIN_PERIOD`: glitch. No output; the counter restarts from this crossing.
  - Otherwise the period is valid and starts the divider if it is idle.
  - If the divider is busy, the valid period is dropped. Counter and hysteresis still update normally.
- Divider FSM:
  - IDLE: waits for a valid period. Loads dividend 2^32 (33 bits) and divisor = period. Goes to DIV.
  - DIV: restoring division, one quotient bit per cycle, 33 iterations. Goes to DONE.
  - DONE: registers the quotient low 32 bits into `phase_incr_out` and the period into `period_out`. Pulses valid. Returns to IDLE.
- Because `MIN_PERIOD ≥ 2`, the quotient is always < 2^32; there is no overflow case.
- `phase_incr_out` and `period_out` hold their values between results.

## Timing

- Reset values:
  - `phase_incr_out=0`, `period_out=0`, `phase_incr_valid_out=0`, `busy_out=0`.
  - Internal: `armed=0`, `have_ref=0`, `cnt=0`, FSM in IDLE.
- Latency, with the valid crossing sample accepted at edge E0:
  - `busy_out` is high from edge E0+1 to edge E0+34. It goes low at E0+34.
  - `phase_incr_out` and `period_out` update at edge E0+34.
  - `phase_incr_valid_out` is high for exactly the one cycle following E0+34.
- Throughput: one result per 34 clocks. Sample rate may be up to 1 sample/clock; excess periods are dropped, never queued.
- A valid crossing at the same edge the FSM returns to IDLE (E0+34) is accepted and starts a new division.
- Reset mid-division aborts immediately:
  - The FSM goes to IDLE and no valid pulse is produced.
  - Outputs revert to their reset values and `have_ref` clears.
- `audio_valid_in` low stalls sample logic only; an in-flight division continues.

## Test plan

1. **Reset.** Assert `rst_in` asynchronously mid-cycle → all outputs 0 immediately. Deassert → no valid pulse until two crossings have been seen.
2. **Square wave.** ±500, period 100 samples, `audio_valid_in` every cycle.
   - First crossing → no pulse.
   - Second crossing → at E0+34, `period_out=100` and `phase_incr_out=42949672`, with one valid pulse.
   - Pulses repeat every 100 cycles.
3. **Sparse strobe.** Sine period 48 samples, `audio_valid_in` every 4th cycle → `period_out=48` and `phase_incr_out=89478485`.
4. **Hysteresis.** `HYST=16`, alternating ±10 noise for 1000 samples → no pulses and `busy_out` never high.
5. **Glitch and timeout.**
   - Crossings 5 samples apart (`MIN_PERIOD=8`) → no pulse.
   - Silence for 70000 samples, then a crossing → no pulse.
   - Next crossing 200 samples later → `period_out=200` and `phase_incr_out=21474836`.
6. **Mid-division reset and busy drop.**
   - Assert `rst_in` 10 cycles after a valid crossing → no pulse, `busy_out=0`. The next crossing only re-establishes the reference.
   - Separately, crossings 20 samples apart at 1 sample/clock → the second period is dropped; exactly one pulse, with `period_out=20`.
